// File: rtl/mac_accumulator_if.sv
// Handshake bundle between the multiplier side, the MAC back end and the
// result consumer.
//
// Handshake rules, for both the product stream and the result:
//   A transfer happens on a rising clock edge where valid and ready are both
//   high. The producer holds valid and its data stable until that edge. The
//   consumer may raise or lower ready at any time. Ready never depends on
//   valid in the same cycle.
interface mac_accumulator_if #(
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
);
   logic             start;
   logic [LEN_W-1:0] length;
   logic             in_valid;
   logic             in_ready;
   logic [15:0]      product;
   logic             out_valid;
   logic             out_ready;
   logic [ACC_W-1:0] acc_out;
   logic             overflow;
   logic             busy;

   // Side that issues runs, supplies products and takes results.
   modport master (
      output start, length, in_valid, product, out_ready,
      input  in_ready, out_valid, acc_out, overflow, busy
   );

   // The accumulator itself.
   modport slave (
      input  start, length, in_valid, product, out_ready,
      output in_ready, out_valid, acc_out, overflow, busy
   );
endinterface

// File: rtl/mac_accumulator.sv
// Sums a programmed run of 16-bit unsigned products into an ACC_W-bit
// accumulator. The sum and a sticky overflow flag are then offered on an
// output handshake. Every output is a flop or a copy of the state register.
module mac_accumulator #(
   parameter int ACC_W = 24,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   mac_accumulator_if.slave bus,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   logic [LEN_W-1:0] remaining;
   logic [ACC_W-1:0] acc;
   logic             ovf;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic [ACC_W:0]   sum_ext;
   logic             beat;

   // One bit wider than the accumulator so the top bit is the carry out.
   assign sum_ext = {1'b0, acc} + (ACC_W+1)'(bus.product);
   assign beat    = bus.in_valid && in_ready_q;

   // Sequencing, accumulation and registered handshake outputs.
   // The handshake flags are updated together with the state transition, so
   // each flag always matches the state it belongs to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         remaining   <= '0;
         acc         <= '0;
         ovf         <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  acc    <= '0;
                  ovf    <= 1'b0;
                  busy_q <= 1'b1;
                  if (bus.length != '0) begin
                     remaining  <= bus.length;
                     in_ready_q <= 1'b1;
                     state      <= ACCUM;
                  end else begin
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            ACCUM: begin
               if (beat) begin
                  acc       <= sum_ext[ACC_W-1:0];
                  ovf       <= ovf | sum_ext[ACC_W];
                  remaining <= remaining - LEN_W'(1);
                  if (remaining == LEN_W'(1)) begin
                     in_ready_q  <= 1'b0;
                     out_valid_q <= 1'b1;
                     state       <= DONE;
                  end
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: begin
               in_ready_q  <= 1'b0;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.busy      = busy_q;
   assign bus.acc_out   = acc;
   assign bus.overflow  = ovf;
   assign fsm_state     = state;

endmodule

// File: tb/tb_mac_accumulator.sv
// Bench for mac_accumulator. Two instances (ACC_W=24 and ACC_W=17) receive
// identical stimulus. The reference model for a run is just the plain integer
// sum of its products: the result is that sum modulo 2^ACC_W, and overflow
// means the sum is at least 2^ACC_W.
module tb_mac_accumulator;

   localparam int LEN_W = 8;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- stimulus signals ----------------
   logic             start;
   logic [LEN_W-1:0] length;
   logic             in_valid;
   logic [15:0]      product;
   logic             out_ready;
   logic [1:0]       state24;
   logic [1:0]       state17;

   mac_accumulator_if #(.ACC_W(24), .LEN_W(LEN_W)) if24 ();
   mac_accumulator_if #(.ACC_W(17), .LEN_W(LEN_W)) if17 ();

   assign if24.start     = start;
   assign if24.length    = length;
   assign if24.in_valid  = in_valid;
   assign if24.product   = product;
   assign if24.out_ready = out_ready;
   assign if17.start     = start;
   assign if17.length    = length;
   assign if17.in_valid  = in_valid;
   assign if17.product   = product;
   assign if17.out_ready = out_ready;

   mac_accumulator #(.ACC_W(24), .LEN_W(LEN_W)) u_dut24 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (if24.slave),
      .fsm_state (state24)
   );

   mac_accumulator #(.ACC_W(17), .LEN_W(LEN_W)) u_dut17 (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (if17.slave),
      .fsm_state (state17)
   );

   // ---------------- scoreboard ----------------
   int          n_checks = 0;
   int          n_fails  = 0;
   logic [15:0] prod_q[$];
   logic [23:0] exp24_q[$];
   logic [16:0] exp17_q[$];
   logic        ovf24_q[$];
   logic        ovf17_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model: queue the expected result of the run held in prod_q.
   task automatic model_push();
      logic [63:0] s;
      s = 64'd0;
      foreach (prod_q[i]) s = s + 64'(prod_q[i]);
      exp24_q.push_back(s[23:0]);
      exp17_q.push_back(s[16:0]);
      ovf24_q.push_back(s > 64'h00FF_FFFF);
      ovf17_q.push_back(s > 64'h0001_FFFF);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready24"},  if24.in_ready,  0);
      check({tag, "_out_valid24"}, if24.out_valid, 0);
      check({tag, "_busy24"},      if24.busy,      0);
      check({tag, "_ovf24"},       if24.overflow,  0);
      check({tag, "_acc24"},       if24.acc_out,   0);
      check({tag, "_in_ready17"},  if17.in_ready,  0);
      check({tag, "_out_valid17"}, if17.out_valid, 0);
      check({tag, "_busy17"},      if17.busy,      0);
      check({tag, "_ovf17"},       if17.overflow,  0);
      check({tag, "_acc17"},       if17.acc_out,   0);
   endtask

   // ---------------- driver ----------------
   // Runs prod_q through both DUTs. Called and returning at posedge+1.
   // stall_pct: chance of an idle cycle; gap: idle cycles forced after beat 0;
   // bp: cycles of out_ready=0 once the result appears; poke: pulse start
   // while busy, which must be ignored.
   task automatic run(input int stall_pct, input int gap, input int bp, input bit poke);
      int          len;
      int          idx;
      int          cyc;
      int          gaps_left;
      logic [23:0] e24;
      logic [16:0] e17;
      logic        o24;
      logic        o17;
      len       = prod_q.size();
      gaps_left = gap;
      model_push();
      start  = 1'b1;
      length = LEN_W'(len);
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_start", if24.busy, 1);
      check("in_ready_after_start", if24.in_ready, (len != 0));
      idx = 0;
      cyc = 0;
      while (idx < len && cyc < 2000) begin
         check("in_ready24_accum", if24.in_ready, 1);
         check("in_ready17_accum", if17.in_ready, 1);
         check("out_valid_accum", if24.out_valid, 0);
         if (idx == 1 && gaps_left > 0) begin
            in_valid = 1'b0;
            gaps_left--;
         end else begin
            in_valid = ($urandom_range(99) >= stall_pct);
         end
         product = in_valid ? prod_q[idx] : 16'($urandom);
         if (poke && $urandom_range(2) == 0) begin
            start  = 1'b1;
            length = LEN_W'($urandom_range(255));
         end
         @(posedge clk); #1;
         start = 1'b0;
         if (in_valid) idx++;
         cyc++;
      end
      in_valid = 1'b0;
      check("beats_sent", idx, len);
      // out_valid must rise the cycle after the last beat (or after start).
      check("out_valid_rise24", if24.out_valid, 1);
      check("out_valid_rise17", if17.out_valid, 1);
      check("in_ready_done", if24.in_ready, 0);
      e24 = exp24_q.pop_front();
      e17 = exp17_q.pop_front();
      o24 = ovf24_q.pop_front();
      o17 = ovf17_q.pop_front();
      out_ready = 1'b0;
      for (int k = 0; k <= bp; k++) begin
         check("out_valid_hold", if24.out_valid & if17.out_valid, 1);
         check("acc24", if24.acc_out, e24);
         check("acc17", if17.acc_out, e17);
         check("ovf24", if24.overflow, o24);
         check("ovf17", if17.overflow, o17);
         if (k == bp) begin
            out_ready = 1'b1;
            if (poke) begin
               start  = 1'b1;
               length = LEN_W'(3);
            end
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      start     = 1'b0;
      check("out_valid_after_take", if24.out_valid | if17.out_valid, 0);
      check("busy_after_take", if24.busy | if17.busy, 0);
      check("acc24_kept", if24.acc_out, e24);
      check("acc17_kept", if17.acc_out, e17);
      @(posedge clk); #1;
      check("idle_stays_idle", if24.busy | if17.in_ready, 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      length    = '0;
      in_valid  = 1'b0;
      product   = '0;
      out_ready = 1'b0;
      #3;
      check_all_zero("por");
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic run.
      prod_q = '{16'd15, 16'd180, 16'd255};
      run(0, 0, 0, 0);
      check("basic_acc24", if24.acc_out, 450);
      check("basic_ovf24", if24.overflow, 0);

      // Stalls and output backpressure.
      prod_q = '{16'd65025, 16'd65025};
      run(0, 2, 3, 0);
      check("stall_acc24", if24.acc_out, 130050);

      // Overflow in the narrow instance, then a clean run clears it.
      prod_q = '{16'd65025, 16'd65025, 16'd65025};
      run(0, 0, 0, 0);
      check("ovf_acc17", if17.acc_out, 64003);
      check("ovf_flag17", if17.overflow, 1);
      check("ovf_acc24", if24.acc_out, 195075);
      prod_q = '{16'd5};
      run(0, 0, 0, 0);
      check("clear_acc17", if17.acc_out, 5);
      check("clear_ovf17", if17.overflow, 0);

      // Zero length.
      prod_q.delete();
      run(0, 0, 1, 0);
      check("zero_acc24", if24.acc_out, 0);

      // Reset in the middle of a five-beat run.
      start  = 1'b1;
      length = LEN_W'(5);
      @(posedge clk); #1;
      start = 1'b0;
      for (int b = 0; b < 2; b++) begin
         in_valid = 1'b1;
         product  = 16'(1000 + b);
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      product  = 16'd3;
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      @(posedge clk); @(posedge clk); #1;
      check_all_zero("in_rst");
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         check("no_out_after_rst", if24.out_valid | if17.out_valid, 0);
         check("idle_after_rst", if24.busy | if24.in_ready, 0);
      end
      in_valid = 1'b0;
      prod_q = '{16'd7};
      run(0, 0, 0, 0);
      check("post_rst_acc24", if24.acc_out, 7);

      // Start pulses while busy are ignored.
      prod_q = '{16'd100, 16'd200, 16'd300, 16'd400, 16'd500, 16'd600};
      run(30, 0, 2, 1);
      check("poke_acc24", if24.acc_out, 2100);

      // Randomized runs.
      for (int r = 0; r < 30; r++) begin
         prod_q.delete();
         for (int i = 0; i < int'($urandom_range(12)); i++) prod_q.push_back(16'($urandom));
         run(int'($urandom_range(50)), int'($urandom_range(2)), int'($urandom_range(3)),
             1'($urandom_range(1)));
      end

      // One maximum-length run of full-scale products.
      prod_q.delete();
      for (int i = 0; i < 255; i++) prod_q.push_back(16'hFFFF);
      run(10, 0, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   // Global time limit.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d checks, expected completion", n_checks);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Sequential multiply-accumulate back end that sits directly downstream of the team's combinational 8x8 Dadda multiplier. It takes a run of 16-bit unsigned products over a valid/ready handshake and sums a programmed number of them into a wide accumulator. It then presents the final sum, with a sticky overflow flag, on an output handshake. This registers and sequences the multiplier's raw combinational result for use in dot-product and filter datapaths.

## Interface
- ACC_W, default 24: accumulator and result width in bits; minimum 16.
- LEN_W, default 8: width of the run-length field; the maximum run is 2^LEN_W-1 products.

- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin a run; sampled only in IDLE.
- length  input  LEN_W  number of products in the run; sampled with start.
- in_valid  input  1  product is valid this cycle.
- in_ready  output  1  block accepts a product this cycle.
- product  input  16  unsigned product from the multiplier.
- out_valid  output  1  result is valid.
- out_ready  input  1  downstream accepts the result.
- acc_out  output  ACC_W  accumulated sum.
- overflow  output  1  sticky flag: the sum exceeded 2^ACC_W-1 during this run.
- busy  output  1  high in any state other than IDLE.

## Operation
- The state machine has three states: IDLE, ACCUM and DONE.
- Reset (rst_n=0, asynchronous) forces:
  - state to IDLE;
  - acc_out, the remaining-count register and overflow to 0;
  - in_ready, out_valid and busy to 0.
- IDLE:
  - in_ready=0 and out_valid=0.
  - On start=1 with length≠0: clear the accumulator and overflow, load remaining=length, go to ACCUM.
  - On start=1 with length=0: clear the accumulator and overflow, go directly to DONE (result 0).
- ACCUM:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready. On each accepted beat:
    - acc ← (acc + zero-extended product) mod 2^ACC_W;
    - overflow ← overflow | carry-out of bit ACC_W-1;
    - remaining decrements by 1.
  - The beat that brings remaining to 0 moves the state to DONE.
  - Cycles with in_valid=0 are stalls: no state change.
- DONE:
  - out_valid=1, in_ready=0.
  - acc_out and overflow are held stable while out_valid=1 && out_ready=0.
  - On out_ready=1 the result is consumed and the state returns to IDLE.
  - acc_out and overflow keep their last values in IDLE until the next start.
- start is ignored outside IDLE, including in the DONE cycle where out_ready=1.
- A product presented while in_ready=0 is not consumed. The upstream stage holds it.
- busy = (state≠IDLE).

## Timing
- All outputs are registered or decoded from registered state. No combinational path runs from any input to any output.
- in_ready rises the cycle after start is accepted.
- Acceptance rate: one product per cycle. A run of N products with no stalls takes N cycles in ACCUM.
- out_valid rises the cycle after the last beat is accepted. With no stalls, start to out_valid is N+1 cycles.
- Length=0: out_valid rises the cycle after start.
- After an out_valid && out_ready handshake, the earliest next start is accepted the following cycle (in IDLE).
- Reset mid-run: the partial sum is discarded and no out_valid is produced. Beats offered during reset are not consumed. After rst_n deasserts, the block waits in IDLE for start.

## Test plan
- Reset values: assert rst_n=0 mid-simulation -> in_ready, out_valid, busy, overflow and acc_out are all 0 immediately, without waiting for a clock edge.
- Basic run, ACC_W=24: start with length=3, then products 15, 180, 255 on consecutive cycles -> out_valid 4 cycles after start, acc_out=450, overflow=0. Holding out_ready=1 returns the block to IDLE the next cycle.
- Stalls and output backpressure: length=2, products 65025 and 65025, with in_valid low for 2 cycles between them; hold out_ready=0 for 3 cycles -> exactly 2 beats accepted, acc_out=130050 held stable while waiting, out_valid stays high until out_ready=1.
- Overflow, ACC_W=17: length=3, product 65025 three times -> acc_out=64003 (195075 mod 131072), overflow=1. The next run (length=1, product 5) -> acc_out=5, overflow=0.
- Zero length: start with length=0 -> out_valid the next cycle, acc_out=0, in_ready never asserted.
- Reset and ignored start:
  - assert rst_n=0 after 2 of 5 beats -> no out_valid;
  - a new run (length=1, product 7) -> acc_out=7;
  - pulsing start during ACCUM or DONE changes neither length nor the running sum.
